// File: rtl/cu_pkg.sv
// Shared state encodings for the control sequencer.
package cu_pkg;

  localparam logic [2:0] ST_START   = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_MEM     = 3'd4;
  localparam logic [2:0] ST_FAULT   = 3'd7;

  typedef enum logic [2:0] {
    S_START   = ST_START,
    S_FETCH   = ST_FETCH,
    S_DECODE  = ST_DECODE,
    S_EXECUTE = ST_EXECUTE,
    S_MEM     = ST_MEM,
    S_FAULT   = ST_FAULT
  } cu_state_e;

endpackage

// File: rtl/cu_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait; flags expiry on the
// cycle the count would reach TIMEOUT while ready is still low.
module cu_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  input  logic ready,
  output logic expired
);

  localparam int          CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIM = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic        EN  = (TIMEOUT > 0);

  logic [CW-1:0] r_cnt;

  // r_cnt holds not-ready cycles already elapsed; saturates at LIM.
  always_ff @(posedge clk) begin
    if (!rst || clear)
      r_cnt <= '0;
    else if (count && !ready && (r_cnt != LIM))
      r_cnt <= r_cnt + 1'b1;
  end

  // A ready in the expiry cycle wins, so ready gates the flag.
  assign expired = EN && count && !ready && (r_cnt == LIM);

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute/mem sequencer with ready/valid waits,
// stall support, selectable branch-flush routing and a sticky wait fault.
module control_sequencer
  import cu_pkg::*;
#(
  parameter int EX_CNT_W     = 4,
  parameter int TIMEOUT      = 16,
  parameter int BRANCH_FLUSH = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_ready,
  input  logic                mem_ready,
  input  logic                stall,
  input  logic                ig_ex,
  input  logic                br_en,
  input  logic                write_rd,
  input  logic                update_flags,
  input  logic                mem_op,
  input  logic                mem_wr,
  input  logic [EX_CNT_W-1:0] ex_cycles,
  output logic                cu_fetch,
  output logic                cu_decode,
  output logic                cu_execute,
  output logic                cu_rd_mem,
  output logic                cu_wr_mem,
  output logic                ld_pc,
  output logic                ld_rd,
  output logic                ld_apsr,
  output logic                cu_branch,
  output logic                cu_fault,
  output logic [2:0]          state
);

  localparam logic FLUSH = (BRANCH_FLUSH != 0);

  cu_state_e           r_state, w_next;
  logic [EX_CNT_W-1:0] r_ex_cnt;
  logic                r_br_l, r_wrd_l, r_upf_l, r_memop_l, r_memwr_l;
  logic                w_wait_cnt, w_ready, w_clear, w_expired;

  // One timer serves both wait states; it restarts on every state change.
  assign w_wait_cnt = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_ready    = (r_state == S_FETCH) ? fetch_ready : mem_ready;
  assign w_clear    = (w_next != r_state);

  cu_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_clear),
    .count   (w_wait_cnt),
    .ready   (w_ready),
    .expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_START;
    else      r_state <= w_next;
  end

  // Decode-field latches and execute counter; branch flag drops after START.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ex_cnt  <= '0;
      r_br_l    <= 1'b0;
      r_wrd_l   <= 1'b0;
      r_upf_l   <= 1'b0;
      r_memop_l <= 1'b0;
      r_memwr_l <= 1'b0;
    end else begin
      case (r_state)
        S_START: r_br_l <= 1'b0;
        S_DECODE: if (!stall) begin
          r_ex_cnt  <= ex_cycles;
          r_br_l    <= br_en;
          r_wrd_l   <= write_rd;
          r_upf_l   <= update_flags;
          r_memop_l <= mem_op;
          r_memwr_l <= mem_wr;
        end
        S_EXECUTE: if (!stall && (r_ex_cnt != '0)) r_ex_cnt <= r_ex_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Next state and all strobes/pulses, decoded from the current state.
  always_comb begin
    w_next     = r_state;
    cu_fetch   = 1'b0;
    cu_decode  = 1'b0;
    cu_execute = 1'b0;
    cu_rd_mem  = 1'b0;
    cu_wr_mem  = 1'b0;
    ld_pc      = 1'b0;
    ld_rd      = 1'b0;
    ld_apsr    = 1'b0;
    cu_branch  = 1'b0;
    cu_fault   = 1'b0;
    case (r_state)
      S_START: begin
        w_next    = S_FETCH;
        cu_branch = FLUSH && r_br_l;
      end
      S_FETCH: begin
        cu_fetch = 1'b1;
        if (fetch_ready) begin
          ld_pc  = 1'b1;
          w_next = S_DECODE;
        end else if (w_expired) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        cu_decode = 1'b1;
        if (!stall) w_next = ig_ex ? S_FETCH : S_EXECUTE;
      end
      S_EXECUTE: begin
        cu_execute = 1'b1;
        if (!stall && (r_ex_cnt == '0)) begin
          if (r_memop_l) begin
            w_next = S_MEM;
          end else begin
            ld_rd   = r_wrd_l;
            ld_apsr = r_upf_l;
            if (r_br_l && FLUSH) begin
              w_next = S_START;
            end else begin
              w_next    = S_FETCH;
              cu_branch = r_br_l;
            end
          end
        end
      end
      S_MEM: begin
        cu_rd_mem = !r_memwr_l;
        cu_wr_mem = r_memwr_l;
        if (mem_ready) begin
          ld_rd = r_wrd_l && !r_memwr_l;
          if (r_br_l && FLUSH) begin
            w_next = S_START;
          end else begin
            w_next    = S_FETCH;
            cu_branch = r_br_l;
          end
        end else if (w_expired) begin
          w_next = S_FAULT;
        end
      end
      S_FAULT: cu_fault = 1'b1;
      default: w_next = S_START;
    endcase
  end

  assign state = r_state;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Parametrised multi-cycle instruction sequencer for the Cortex-M0 core; next generation of the four-state fetch/decode/execute control unit.
Adds ready/valid handshakes to instruction and data memory, variable-length execute (multi-cycle ops), a dedicated memory phase, decode/execute stall, configurable branch-flush mode and a wait timeout with sticky fault.
Drives the datapath load enables (PC, Rd, APSR) and the memory strobes.

Parameters:
EX_CNT_W, 4, width of ex_cycles; extra execute cycles 0..2^EX_CNT_W-1
TIMEOUT, 16, max wait cycles on fetch_ready/mem_ready before fault; 0 disables timeout
BRANCH_FLUSH, 1, 1: taken branch routes through START (one-cycle flush, cu_branch there); 0: cu_branch on final execute/mem cycle, then straight to FETCH

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk)
fetch_ready  in  1  instruction memory has delivered the word this cycle
mem_ready  in  1  data memory access completes this cycle
stall  in  1  hazard stall; honoured only in DECODE and EXECUTE
ig_ex  in  1  decoder: skip execute (valid in DECODE)
br_en  in  1  decoder: branch taken (valid in DECODE)
write_rd  in  1  decoder: instruction writes Rd (valid in DECODE)
update_flags  in  1  decoder: instruction writes APSR (valid in DECODE)
mem_op  in  1  decoder: instruction needs data-memory phase (valid in DECODE)
mem_wr  in  1  decoder: memory phase is a store (valid in DECODE)
ex_cycles  in  EX_CNT_W  decoder: extra execute cycles (valid in DECODE)
cu_fetch  out  1  level, high in FETCH
cu_decode  out  1  level, high in DECODE
cu_execute  out  1  level, high in EXECUTE
cu_rd_mem  out  1  level, high in MEM for loads
cu_wr_mem  out  1  level, high in MEM for stores
ld_pc  out  1  pulse, PC increment
ld_rd  out  1  pulse, register file write
ld_apsr  out  1  pulse, flag write
cu_branch  out  1  pulse, load branch target into PC
cu_fault  out  1  sticky timeout fault
state  out  3  current state encoding (debug)

Behaviour:
- States: START=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, FAULT=7. Others unreachable; if ever entered, next state is START.
- Reset (rst=0 at edge): state=START; ex counter, wait counter and all latched decode fields cleared; every output 0 (state=0).
- START: one cycle, then FETCH. cu_branch=1 here only if BRANCH_FLUSH=1 and the latched branch flag is set; the flag clears on leaving START.
- FETCH: cu_fetch=1 until fetch_ready. ld_pc=1 on exactly the cycle fetch_ready=1, then DECODE. Min fetch latency 1 cycle.
- DECODE: latch br_en, write_rd, update_flags, mem_op, mem_wr, ex_cycles into ex counter.
  - stall=1: hold DECODE, do not latch.
  - ig_ex=1: go to FETCH, no ld_rd/ld_apsr/cu_branch.
  - Otherwise go to EXECUTE.
- EXECUTE: stays (latched ex_cycles + 1) cycles; counter decrements each non-stalled cycle. stall freezes counter and state; all pulses suppressed while stall=1.
- EXECUTE final cycle (counter=0, stall=0), when mem_op_l=1: go to MEM, no pulses.
- EXECUTE final cycle, when mem_op_l=0:
  - ld_rd=write_rd_l and ld_apsr=update_flags_l.
  - Next state START if br_l and BRANCH_FLUSH=1.
  - Otherwise FETCH; cu_branch=br_l same cycle when BRANCH_FLUSH=0.
- MEM: cu_rd_mem=!mem_wr_l, cu_wr_mem=mem_wr_l until mem_ready. On the mem_ready cycle: ld_rd=write_rd_l & !mem_wr_l, ld_apsr=0, branch routing as in EXECUTE. stall is ignored.
- Wait counter: counts consecutive not-ready cycles in FETCH/MEM; cleared on state change.
  - If TIMEOUT>0 and it reaches TIMEOUT while ready=0, go to FAULT next cycle.
  - FAULT: all strobes/pulses 0, cu_fault=1, held until reset.
  - A ready arriving in the same cycle the counter hits TIMEOUT wins (no fault).
- Reset mid-operation (any state, incl. MEM/FAULT) returns to START next edge and clears cu_fault.
- At most one of cu_fetch/cu_decode/cu_execute/cu_rd_mem/cu_wr_mem high per cycle.

Decomposition:
- Package cu_pkg: state encodings (localparams ST_START..ST_FAULT, 3 bits).
- One sub-module, cu_wait_timer (TIMEOUT parameter; inputs clear/count/ready; output expired), instantiated once and shared by FETCH and MEM.

Test Plan:
- Reset, then fetch_ready=1 every cycle, ig_ex=0, ex_cycles=0, write_rd=1, update_flags=1 -> state 0,1,2,3,1,...; ld_pc every 3rd cycle; ld_rd and ld_apsr pulse in each EXECUTE.
- ex_cycles=3, stall=1 for 2 cycles mid-EXECUTE -> cu_execute high 6 cycles; ld_rd single pulse on last.
- Load: mem_op=1, mem_wr=0, mem_ready after 4 cycles -> cu_rd_mem high 5 cycles; ld_rd one pulse on ready; ld_apsr=0. Store: same with mem_wr=1 -> cu_wr_mem high; ld_rd=0.
- br_en=1, BRANCH_FLUSH=1 -> EXECUTE, START (cu_branch=1), FETCH. BRANCH_FLUSH=0 -> cu_branch on final EXECUTE cycle, next state FETCH.
- TIMEOUT=4, fetch_ready held 0 -> FAULT after 4 wait cycles, cu_fault=1 sticky. fetch_ready=1 on the 4th wait cycle -> no fault.
- rst=0 asserted during MEM wait and in FAULT -> next edge state=0, all outputs 0, cu_fault cleared. ig_ex=1 in DECODE -> straight to FETCH, no ld_rd.
